// File: rtl/bcd_stopwatch_pkg.sv
// Shared state encoding, BCD limits and the per-digit increment helper
// used by the stopwatch top level.
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } sw_state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    logic       carry;
    logic [3:0] value;
  } digit_step_t;

  // Anything at or above the limit rolls to zero, so a corrupted digit heals on its next increment.
  function automatic digit_step_t digit_step(input logic [3:0] d,
                                             input logic [3:0] max,
                                             input logic       cin);
    digit_step_t r;
    r.carry = 1'b0;
    r.value = d;
    if (cin) begin
      if (d >= max) begin
        r.value = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.value = d + 4'd1;
      end
    end else begin
      r.value = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_key_debounce.sv
// Raw active-low pushbutton to single-cycle press pulse: 2-FF synchronizer,
// consecutive-cycle debounce and registered falling-edge detect.
module key_debounce
  import bcd_stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Metastability synchronizer, idles at the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Level flips only after DEB_CYCLES straight cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b1;
    end else if (sync2_r != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  // Registered 1->0 detect; release produces nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d_r <= 1'b1;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_d_r & ~level_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.cc, 00.00..59.99) with debounced start/stop
// and clear keys; the digits feed the seven-segment decoders directly.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        KEY_START,
  input  logic        KEY_CLEAR,
  output logic [15:0] DIGITS,
  output logic        RUNNING,
  output logic        WRAP
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic          start_press_s;
  logic          clear_press_s;
  sw_state_e     state_r;
  sw_state_e     state_next_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_next_s;
  logic          tick_s;
  logic [15:0]   digits_r;
  logic [15:0]   digits_next_s;
  logic          wrap_next_s;
  logic          wrap_r;
  logic          running_r;
  digit_step_t   cs_ones_s;
  digit_step_t   cs_tens_s;
  digit_step_t   s_ones_s;
  digit_step_t   s_tens_s;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .key_n (KEY_START),
    .press (start_press_s)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_clear (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .key_n (KEY_CLEAR),
    .press (clear_press_s)
  );

  // Run/pause/idle sequencing; clear dominates a simultaneous start.
  always_comb begin
    state_next_s = state_r;
    if (clear_press_s) begin
      state_next_s = IDLE;
    end else if (start_press_s) begin
      case (state_r)
        IDLE:    state_next_s = RUN;
        RUN:     state_next_s = PAUSED;
        PAUSED:  state_next_s = RUN;
        default: state_next_s = IDLE;
      endcase
    end else begin
      case (state_r)
        IDLE, RUN, PAUSED: state_next_s = state_r;
        default:           state_next_s = IDLE;
      endcase
    end
  end

  // Prescaler: advances in RUN, freezes in PAUSED so a resumed fraction is kept.
  always_comb begin
    tick_s       = (state_r == RUN) && (presc_r >= PRESC_LAST) && !clear_press_s;
    presc_next_s = presc_r;
    if (clear_press_s) begin
      presc_next_s = {PW{1'b0}};
    end else begin
      case (state_r)
        RUN:     presc_next_s = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
        PAUSED:  presc_next_s = presc_r;
        default: presc_next_s = {PW{1'b0}};
      endcase
    end
  end

  // Ripple-carry BCD cascade; the top-digit carry is exactly the 59.99 rollover.
  always_comb begin
    cs_ones_s = digit_step(digits_r[3:0],   DIGIT_MAX,    tick_s);
    cs_tens_s = digit_step(digits_r[7:4],   DIGIT_MAX,    cs_ones_s.carry);
    s_ones_s  = digit_step(digits_r[11:8],  DIGIT_MAX,    cs_tens_s.carry);
    s_tens_s  = digit_step(digits_r[15:12], SEC_TENS_MAX, s_ones_s.carry);
    digits_next_s = digits_r;
    wrap_next_s   = 1'b0;
    if (clear_press_s) begin
      digits_next_s = 16'h0000;
      wrap_next_s   = 1'b0;
    end else begin
      digits_next_s = {s_tens_s.value, s_ones_s.value, cs_tens_s.value, cs_ones_s.value};
      wrap_next_s   = s_tens_s.carry;
    end
  end

  // State, count and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_r   <= IDLE;
      presc_r   <= {PW{1'b0}};
      digits_r  <= 16'h0000;
      wrap_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      presc_r   <= presc_next_s;
      digits_r  <= digits_next_s;
      wrap_r    <= wrap_next_s;
      running_r <= (state_next_s == RUN);
    end
  end

  assign DIGITS  = digits_r;
  assign RUNNING = running_r;
  assign WRAP    = wrap_r;

endmodule
